// File: rtl/pair_match_engine_pkg.sv
// Shared types and helpers for the memory-game pair match engine.
package pair_match_engine_pkg;

  localparam int NUM_CARDS = 16;
  localparam int SYM_W     = 4;
  localparam int BOARD_W   = NUM_CARDS * SYM_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FIRST  = 3'd1,
    ST_SECOND = 3'd2,
    ST_CHECK  = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Card idx occupies bits [4*idx+3 : 4*idx] of a board word.
  function automatic logic [SYM_W-1:0] nibble(input logic [BOARD_W-1:0] board,
                                               input logic [3:0]         idx);
    nibble = board[{idx, 2'b00} +: SYM_W];
  endfunction

endpackage

// File: rtl/pair_match_engine_hold_timer.sv
// Reveal hold timer: start arms a count of HOLD_CYCLES cycles, done pulses on the last one.
module hold_timer #(
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic done
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             running_q, running_d;

  assign done = running_q && (cnt_q == LAST);

  always_comb begin
    cnt_d     = cnt_q;
    running_d = running_q;
    if (abort) begin
      cnt_d     = '0;
      running_d = 1'b0;
    end else if (start) begin
      cnt_d     = '0;
      running_d = 1'b1;
    end else if (done) begin
      cnt_d     = '0;
      running_d = 1'b0;
    end else if (running_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      running_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      running_q <= running_d;
    end
  end

endmodule

// File: rtl/pair_match_engine.sv
// Memory-game pick/compare/hold engine. Optional MISS_LIMIT_EN ends the game after MAX_MISSES misses.
// Inputs are plain strobes (pick_valid, new_game): sampled on any posedge they are high, no ready/backpressure.
module pair_match_engine
  import pair_match_engine_pkg::*;
#(
  parameter int HOLD_CYCLES = 50000000
`ifdef MISS_LIMIT_EN
  , parameter int MAX_MISSES = 8
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic [63:0] board_x,
  input  logic [63:0] board_y,
  input  logic        pick_valid,
  input  logic [3:0]  pick_idx,
  output logic        pick_err,
  output logic [15:0] revealed_mask,
  output logic [15:0] matched_mask,
  output logic [3:0]  reveal_idx_a,
  output logic [3:0]  reveal_idx_b,
  output logic [3:0]  reveal_col_a,
  output logic [3:0]  reveal_col_b,
  output logic        match_pulse,
  output logic        miss_pulse,
  output logic [7:0]  attempts,
  output logic        game_done,
  output logic [2:0]  dbg_state
);

  state_e        state_q, state_d;
  logic [63:0]   board_x_q, board_x_d, board_y_q, board_y_d;
  logic [15:0]   matched_q, matched_d, revealed_q, revealed_d;
  logic [3:0]    idx_a_q, idx_a_d, idx_b_q, idx_b_d;
  logic [3:0]    col_a_q, col_a_d, col_b_q, col_b_d;
  logic          match_q, match_d, miss_q, miss_d, err_q, err_d;
  logic [7:0]    attempts_q, attempts_d;
  logic          tmr_start, tmr_done;
`ifdef MISS_LIMIT_EN
  localparam logic [7:0] MISS_LIMIT = 8'(MAX_MISSES);
  logic [7:0]    misses_q, misses_d;
`endif

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .start (tmr_start),
    .abort (new_game),
    .done  (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    board_x_d  = board_x_q;
    board_y_d  = board_y_q;
    matched_d  = matched_q;
    revealed_d = revealed_q;
    idx_a_d    = idx_a_q;
    idx_b_d    = idx_b_q;
    col_a_d    = col_a_q;
    col_b_d    = col_b_q;
    attempts_d = attempts_q;
    match_d    = 1'b0;
    miss_d     = 1'b0;
    err_d      = 1'b0;
    tmr_start  = 1'b0;
`ifdef MISS_LIMIT_EN
    misses_d   = misses_q;
`endif
    // new_game wins over everything, including a pick in the same cycle.
    if (new_game) begin
      state_d    = ST_FIRST;
      board_x_d  = board_x;
      board_y_d  = board_y;
      matched_d  = '0;
      revealed_d = '0;
      idx_a_d    = '0;
      idx_b_d    = '0;
      col_a_d    = '0;
      col_b_d    = '0;
      attempts_d = '0;
`ifdef MISS_LIMIT_EN
      misses_d   = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: err_d = pick_valid;
        ST_FIRST: begin
          if (pick_valid) begin
            if (matched_q[pick_idx]) begin
              err_d = 1'b1;
            end else begin
              idx_a_d              = pick_idx;
              col_a_d              = nibble(board_y_q, pick_idx);
              revealed_d[pick_idx] = 1'b1;
              state_d              = ST_SECOND;
            end
          end
        end
        ST_SECOND: begin
          if (pick_valid) begin
            if (matched_q[pick_idx] || (pick_idx == idx_a_q)) begin
              err_d = 1'b1;
            end else begin
              idx_b_d              = pick_idx;
              col_b_d              = nibble(board_y_q, pick_idx);
              revealed_d[pick_idx] = 1'b1;
              state_d              = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          tmr_start = 1'b1;
          state_d   = ST_HOLD;
          if (attempts_q != 8'hFF) attempts_d = attempts_q + 8'd1;
          if (nibble(board_x_q, idx_a_q) == nibble(board_x_q, idx_b_q)) begin
            matched_d[idx_a_q] = 1'b1;
            matched_d[idx_b_q] = 1'b1;
            match_d            = 1'b1;
          end else begin
            miss_d = 1'b1;
`ifdef MISS_LIMIT_EN
            if (misses_q != 8'hFF) misses_d = misses_q + 8'd1;
`endif
          end
        end
        ST_HOLD: begin
          err_d = pick_valid;
          if (tmr_done) begin
            revealed_d = matched_q;
            if (matched_q == 16'hFFFF) begin
              state_d = ST_DONE;
`ifdef MISS_LIMIT_EN
            end else if (misses_q == MISS_LIMIT) begin
              state_d = ST_DONE;
`endif
            end else begin
              state_d = ST_FIRST;
            end
          end
        end
        ST_DONE: err_d = pick_valid;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      board_x_q  <= '0;
      board_y_q  <= '0;
      matched_q  <= '0;
      revealed_q <= '0;
      idx_a_q    <= '0;
      idx_b_q    <= '0;
      col_a_q    <= '0;
      col_b_q    <= '0;
      attempts_q <= '0;
      match_q    <= 1'b0;
      miss_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef MISS_LIMIT_EN
      misses_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      board_x_q  <= board_x_d;
      board_y_q  <= board_y_d;
      matched_q  <= matched_d;
      revealed_q <= revealed_d;
      idx_a_q    <= idx_a_d;
      idx_b_q    <= idx_b_d;
      col_a_q    <= col_a_d;
      col_b_q    <= col_b_d;
      attempts_q <= attempts_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      err_q      <= err_d;
`ifdef MISS_LIMIT_EN
      misses_q   <= misses_d;
`endif
    end
  end

  assign pick_err      = err_q;
  assign revealed_mask = revealed_q;
  assign matched_mask  = matched_q;
  assign reveal_idx_a  = idx_a_q;
  assign reveal_idx_b  = idx_b_q;
  assign reveal_col_a  = col_a_q;
  assign reveal_col_b  = col_b_q;
  assign match_pulse   = match_q;
  assign miss_pulse    = miss_q;
  assign attempts      = attempts_q;
  assign game_done     = (state_q == ST_DONE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_pair_match_engine.sv
// Directed self-checking bench for pair_match_engine with HOLD_CYCLES = 4.
module tb_pair_match_engine;

  localparam logic [63:0] BX_A = 64'h3A71628D53C493E6;
  localparam logic [63:0] BY_A = 64'hFA276435902E7342;
  localparam logic [63:0] BX_F = 64'h7766554433221100;
  localparam logic [63:0] BY_F = 64'h0123456789ABCDEF;
`ifdef MISS_LIMIT_EN
  localparam logic EXP_LIMIT_DONE = 1'b1;
`else
  localparam logic EXP_LIMIT_DONE = 1'b0;
`endif

  logic        clk, rst, new_game, pick_valid;
  logic [63:0] board_x, board_y;
  logic [3:0]  pick_idx;
  logic        pick_err, match_pulse, miss_pulse, game_done;
  logic [15:0] revealed_mask, matched_mask;
  logic [3:0]  reveal_idx_a, reveal_idx_b, reveal_col_a, reveal_col_b;
  logic [7:0]  attempts;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  pair_match_engine #(
    .HOLD_CYCLES(4)
`ifdef MISS_LIMIT_EN
    , .MAX_MISSES(2)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .new_game      (new_game),
    .board_x       (board_x),
    .board_y       (board_y),
    .pick_valid    (pick_valid),
    .pick_idx      (pick_idx),
    .pick_err      (pick_err),
    .revealed_mask (revealed_mask),
    .matched_mask  (matched_mask),
    .reveal_idx_a  (reveal_idx_a),
    .reveal_idx_b  (reveal_idx_b),
    .reveal_col_a  (reveal_col_a),
    .reveal_col_b  (reveal_col_b),
    .match_pulse   (match_pulse),
    .miss_pulse    (miss_pulse),
    .attempts      (attempts),
    .game_done     (game_done),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change 1 time unit after posedge, outputs are read there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pick(input logic [3:0] idx);
    pick_valid = 1'b1;
    pick_idx   = idx;
    tick();
    pick_valid = 1'b0;
  endtask

  task automatic start(input logic [63:0] x, input logic [63:0] y);
    new_game = 1'b1;
    board_x  = x;
    board_y  = y;
    tick();
    new_game = 1'b0;
    board_x  = {$urandom(), $urandom()};
    board_y  = {$urandom(), $urandom()};
  endtask

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; new_game = 1'b0; pick_valid = 1'b0; pick_idx = '0;
    board_x = '0; board_y = '0;
    ticks(2);
    rst = 1'b0;

    // reset state and pick before any board
    check_eq("rst_revealed", revealed_mask, 0);
    check_eq("rst_matched", matched_mask, 0);
    check_eq("rst_attempts", attempts, 0);
    check_eq("rst_done", game_done, 0);
    check_eq("rst_state", dbg_state, 0);
    pick(4'd3);
    check_eq("idle_pick_err", pick_err, 1);
    check_eq("idle_revealed", revealed_mask, 0);

    // match: cards 0 and 11 both symbol 6
    start(BX_A, BY_A);
    check_eq("ng_state", dbg_state, 1);
    pick(4'd0);
    check_eq("m_rev_a", revealed_mask, 16'h0001);
    check_eq("m_col_a", reveal_col_a, 4'h2);
    pick(4'd11);
    check_eq("m_rev_b", revealed_mask, 16'h0801);
    check_eq("m_col_b", reveal_col_b, 4'h6);
    check_eq("m_idx_b", reveal_idx_b, 4'd11);
    check_eq("m_pulse_early", match_pulse, 0);
    tick();
    check_eq("m_pulse", match_pulse, 1);
    check_eq("m_miss", miss_pulse, 0);
    check_eq("m_matched", matched_mask, 16'h0801);
    check_eq("m_attempts", attempts, 1);
    pick(4'd4);
    check_eq("hold_pick_err", pick_err, 1);
    check_eq("hold_revealed", revealed_mask, 16'h0801);
    ticks(3);
    check_eq("m_back_first", dbg_state, 1);
    check_eq("m_rev_keep", revealed_mask, 16'h0801);

    // mismatch: cards 1 (E) and 3 (9)
    pick(4'd1);
    pick(4'd3);
    check_eq("x_rev", revealed_mask, 16'h080B);
    tick();
    check_eq("x_miss", miss_pulse, 1);
    check_eq("x_match", match_pulse, 0);
    check_eq("x_matched", matched_mask, 16'h0801);
    check_eq("x_attempts", attempts, 2);
    tick();
    check_eq("x_miss_once", miss_pulse, 0);
    ticks(2);
    check_eq("x_rev_last_hold", revealed_mask, 16'h080B);
    tick();
    check_eq("x_rev_cleared", revealed_mask, 16'h0801);
    check_eq("x_state", dbg_state, 1);

    // rejects
    pick(4'd0);
    check_eq("rej_matched_first", pick_err, 1);
    check_eq("rej_matched_state", dbg_state, 1);
    pick(4'd5);
    check_eq("rej_first_ok", pick_err, 0);
    check_eq("rej_rev5", revealed_mask, 16'h0821);
    pick(4'd5);
    check_eq("rej_same", pick_err, 1);
    check_eq("rej_same_state", dbg_state, 2);
    pick(4'd11);
    check_eq("rej_matched_second", pick_err, 1);
    check_eq("rej_rev_hold", revealed_mask, 16'h0821);

    // reset mid-SECOND
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst2_revealed", revealed_mask, 0);
    check_eq("rst2_matched", matched_mask, 0);
    check_eq("rst2_attempts", attempts, 0);
    check_eq("rst2_idx_a", reveal_idx_a, 0);
    check_eq("rst2_col_a", reveal_col_a, 0);
    check_eq("rst2_state", dbg_state, 0);
    pick(4'd2);
    check_eq("rst2_pick_err", pick_err, 1);

    // full game
    start(BX_F, BY_F);
    for (int p = 0; p < 8; p++) begin
      pick(4'(2 * p));
      pick(4'(2 * p + 1));
      tick();
      check_eq("full_match", match_pulse, 1);
      ticks(4);
    end
    check_eq("full_matched", matched_mask, 16'hFFFF);
    check_eq("full_revealed", revealed_mask, 16'hFFFF);
    check_eq("full_done", game_done, 1);
    check_eq("full_attempts", attempts, 8);
    pick(4'd4);
    check_eq("done_pick_err", pick_err, 1);
    check_eq("done_stays", game_done, 1);

    // mid-hold restart with a simultaneous pick
    start(BX_F, BY_F);
    pick(4'd0);
    pick(4'd1);
    tick();
    check_eq("mh_matched", matched_mask, 16'h0003);
    new_game   = 1'b1;
    board_x    = BX_A;
    board_y    = BY_A;
    pick_valid = 1'b1;
    pick_idx   = 4'd5;
    tick();
    new_game   = 1'b0;
    pick_valid = 1'b0;
    check_eq("mh_matched_clr", matched_mask, 0);
    check_eq("mh_revealed_clr", revealed_mask, 0);
    check_eq("mh_attempts_clr", attempts, 0);
    check_eq("mh_no_err", pick_err, 0);
    check_eq("mh_state", dbg_state, 1);
    pick(4'd0);
    pick(4'd1);
    tick();
    check_eq("mh_newboard_miss", miss_pulse, 1);
    check_eq("mh_newboard_col", reveal_col_a, 4'h2);
    ticks(4);

    // two misses: ends the game only with the miss limit enabled
    start(BX_A, BY_A);
    pick(4'd1);
    pick(4'd3);
    ticks(5);
    check_eq("lim_first_done", game_done, 0);
    pick(4'd1);
    pick(4'd3);
    tick();
    check_eq("lim_miss2", miss_pulse, 1);
    ticks(3);
    check_eq("lim_hold_done", game_done, 0);
    tick();
    check_eq("lim_done", game_done, EXP_LIMIT_DONE);
    check_eq("lim_revealed", revealed_mask, 0);
    pick(4'd7);
    check_eq("lim_pick_err", pick_err, EXP_LIMIT_DONE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
